// File: rtl/memory_bist_pkg.sv
// Shared types and defaults for the memory BIST initiator: state encoding,
// default geometry and the address/seed data pattern.
package memory_bist_pkg;

  localparam int BIST_ADDR_W = 10;
  localparam int BIST_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    W0,
    R0,
    W1,
    R1,
    DONE
  } bist_state_t;

  // Callers keep the low DATA_W bits; wide operands let one function serve
  // every ADDR_W/DATA_W pairing.
  function automatic logic [31:0] bist_pat(input logic [31:0] addr, input logic [31:0] seed);
    return addr ^ seed;
  endfunction

endpackage

// File: rtl/memory_bist.sv
// Memory BIST initiator: writes a seeded pattern to every address, reads it back
// and reports pass/first failing address. MEMORY_BIST_INV_PASS_EN adds inverse W1/R1 phases.
module memory_bist
  import memory_bist_pkg::*;
#(
  parameter int ADDR_W = BIST_ADDR_W,
  parameter int DATA_W = BIST_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              mem_wrEna,
  output logic [DATA_W-1:0] mem_wrData,
  output logic [ADDR_W-1:0] mem_wrAddr,
  output logic [ADDR_W-1:0] mem_rdAddr,
  input  logic [DATA_W-1:0] mem_rdData
);

  // Handshake: start is a level sampled only in IDLE; done is a one-cycle pulse
  // and pass/fail_addr are valid from that cycle until the next accepted start.

  bist_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] seed_q;
  logic [31:0]       pat_full;
  logic [DATA_W-1:0] pat;
  logic [DATA_W-1:0] exp_data;
  logic              last_addr;
  logic              mismatch;
  logic              unused_pat;

  assign pat_full   = bist_pat(32'(addr), 32'(seed_q));
  assign pat        = pat_full[DATA_W-1:0];
  assign unused_pat = ^pat_full[31:DATA_W];
  assign last_addr  = (addr == {ADDR_W{1'b1}});

  // Memory port decode depends only on registered state, addr and seed_q.
  always_comb begin
    mem_wrEna  = 1'b0;
    mem_wrData = '0;
    mem_wrAddr = '0;
    mem_rdAddr = '0;
    exp_data   = pat;
    mismatch   = 1'b0;
    case (state)
      W0: begin
        mem_wrEna  = 1'b1;
        mem_wrAddr = addr;
        mem_wrData = pat;
      end
      R0: mem_rdAddr = addr;
`ifdef MEMORY_BIST_INV_PASS_EN
      W1: begin
        mem_wrEna  = 1'b1;
        mem_wrAddr = addr;
        mem_wrData = ~pat;
      end
      R1: begin
        mem_rdAddr = addr;
        exp_data   = ~pat;
      end
`endif
      default: ;
    endcase
    mismatch = ((state == R0) || (state == R1)) && (mem_rdData != exp_data);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      seed_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            seed_q    <= seed;
            pass      <= 1'b1;
            fail_addr <= '0;
            addr      <= '0;
            busy      <= 1'b1;
            state     <= W0;
          end
        end
        W0: begin
          addr <= addr + 1'b1;
          if (last_addr) state <= R0;
        end
        R0: begin
          addr <= addr + 1'b1;
          if (mismatch) begin
            pass      <= 1'b0;
            fail_addr <= addr;
            addr      <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (last_addr) begin
`ifdef MEMORY_BIST_INV_PASS_EN
            state <= W1;
`else
            done  <= 1'b1;
            state <= DONE;
`endif
          end
        end
`ifdef MEMORY_BIST_INV_PASS_EN
        W1: begin
          addr <= addr + 1'b1;
          if (last_addr) state <= R1;
        end
        R1: begin
          addr <= addr + 1'b1;
          if (mismatch) begin
            pass      <= 1'b0;
            fail_addr <= addr;
            addr      <= '0;
            done      <= 1'b1;
            state     <= DONE;
          end else if (last_addr) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
